// File: rtl/led_fade_pwm_if.sv
// Bundle between the 4-LED chaser (master) and the PWM fader (slave), plus
// per-channel duty and state read-back for observing the fade.
interface led_fade_pwm_if;
  // Level-based, no valid/ready: led_in and fade_en are sampled on every clk,
  // and led_out/busy are registered outputs that update every clk.
  logic [3:0]      led_in;
  logic            fade_en;
  logic [3:0]      led_out;
  logic            busy;
  logic [3:0][7:0] duty;
  logic [3:0][1:0] state;

  modport master (
    output led_in, fade_en,
    input  led_out, busy, duty, state
  );

  modport slave (
    input  led_in, fade_en,
    output led_out, busy, duty, state
  );
endinterface

// File: rtl/led_fade_pwm.sv
// Four-channel PWM fader: each LED ramps linearly toward full on/off, or steps
// straight to its target at the next PWM period boundary when fade_en is low.
module led_fade_pwm #(
  parameter int CLOCK_FREQ        = 100_000_000,
  parameter int PWM_DIV           = 4,
  parameter int FADE_STEP_PERIODS = 100
) (
  input logic           clk,
  input logic           rst,
  led_fade_pwm_if.slave bus
);

  localparam int DIV_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int FADE_W = (FADE_STEP_PERIODS > 1) ? $clog2(FADE_STEP_PERIODS) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(PWM_DIV - 1);
  localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_STEP_PERIODS - 1);

  if (PWM_DIV < 1 || FADE_STEP_PERIODS < 1 || CLOCK_FREQ < 1) begin : g_bad_param
    $error("led_fade_pwm: PWM_DIV, FADE_STEP_PERIODS and CLOCK_FREQ must be >= 1");
  end

  typedef enum logic [1:0] {
    CH_OFF  = 2'd0,
    CH_RISE = 2'd1,
    CH_ON   = 2'd2,
    CH_FALL = 2'd3
  } ch_state_t;

  logic [DIV_W-1:0]  div_cnt;
  logic [7:0]        pwm_cnt;
  logic [FADE_W-1:0] fade_cnt;
  logic              step;
  logic              period_end;
  logic              fade_tick;

  logic [3:0][7:0]   duty;
  logic [3:0][7:0]   duty_next;
  logic [3:0][7:0]   target;
  ch_state_t         ch_state [4];

  assign step       = (div_cnt == DIV_LAST);
  assign period_end = step && (pwm_cnt == 8'hFF);
  assign fade_tick  = period_end && (fade_cnt == FADE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      pwm_cnt  <= '0;
      fade_cnt <= '0;
    end else begin
      div_cnt <= step ? '0 : div_cnt + 1'b1;
      if (step) begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
      if (period_end) begin
        fade_cnt <= (fade_cnt == FADE_LAST) ? '0 : fade_cnt + 1'b1;
      end
    end
  end

  // Duty is the per-channel state register; the channel state is derived from
  // duty against the live target, so a flipped led_in reverses from where it is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty <= '0;
    end else begin
      duty <= duty_next;
    end
  end

  always_comb begin
    duty_next = duty;
    target    = '0;
    bus.state = '0;
    for (int i = 0; i < 4; i++) begin
      target[i] = bus.led_in[i] ? 8'hFF : 8'h00;
      if (duty[i] < target[i]) begin
        ch_state[i] = CH_RISE;
      end else if (duty[i] > target[i]) begin
        ch_state[i] = CH_FALL;
      end else if (target[i] == 8'hFF) begin
        ch_state[i] = CH_ON;
      end else begin
        ch_state[i] = CH_OFF;
      end
      bus.state[i] = ch_state[i];

      if (!bus.fade_en) begin
        if (period_end) begin
          duty_next[i] = target[i];
        end
      end else if (fade_tick) begin
        // RISE implies duty < 255 and FALL implies duty > 0, so no wrap.
        case (ch_state[i])
          CH_RISE: duty_next[i] = duty[i] + 8'd1;
          CH_FALL: duty_next[i] = duty[i] - 8'd1;
          default: duty_next[i] = duty[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.led_out <= '0;
      bus.busy    <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        bus.led_out[i] <= (duty[i] == 8'hFF) | (pwm_cnt < duty[i]);
      end
      bus.busy <= (duty != target);
    end
  end

  assign bus.duty = duty;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench for led_fade_pwm: four instances run their scenarios in parallel; duty
// updates of three of them are checked against expected queues by monitors.
module tb_led_fade_pwm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c, rst_d;
  int   tests_run    = 0;
  int   tests_failed = 0;

  led_fade_pwm_if bus_a ();
  led_fade_pwm_if bus_b ();
  led_fade_pwm_if bus_c ();
  led_fade_pwm_if bus_d ();

  led_fade_pwm #(.PWM_DIV(1), .FADE_STEP_PERIODS(1)) u_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  led_fade_pwm #(.PWM_DIV(1), .FADE_STEP_PERIODS(1)) u_b (.clk(clk), .rst(rst_b), .bus(bus_b));
  led_fade_pwm #(.PWM_DIV(1), .FADE_STEP_PERIODS(1)) u_c (.clk(clk), .rst(rst_c), .bus(bus_c));
  led_fade_pwm #(.PWM_DIV(2), .FADE_STEP_PERIODS(3)) u_d (.clk(clk), .rst(rst_d), .bus(bus_d));

  logic [31:0] exp_q_a[$];
  logic [31:0] exp_q_b[$];
  logic [31:0] exp_q_c[$];
  logic [31:0] prev_a = '0, prev_b = '0, prev_c = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_compare(input string name, input logic [31:0] act, inout logic [31:0] q[$]);
    if (q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s: unexpected duty 0x%0h, expected nothing", name, act);
    end else begin
      check(name, act, q.pop_front());
    end
  endtask

  // Monitors: every visible duty change pops one expected duty vector.
  always @(negedge clk) begin
    if (rst_a) prev_a = '0;
    else if (bus_a.duty != prev_a) begin
      prev_a = bus_a.duty;
      sb_compare("sb_a_duty", bus_a.duty, exp_q_a);
    end
    if (rst_b) prev_b = '0;
    else if (bus_b.duty != prev_b) begin
      prev_b = bus_b.duty;
      sb_compare("sb_b_duty", bus_b.duty, exp_q_b);
    end
    if (rst_c) prev_c = '0;
    else if (bus_c.duty != prev_c) begin
      prev_c = bus_c.duty;
      sb_compare("sb_c_duty", bus_c.duty, exp_q_c);
    end
  end

  function automatic logic [7:0] get_duty(input int inst, input int ch);
    case (inst)
      0:       return bus_a.duty[ch];
      1:       return bus_b.duty[ch];
      2:       return bus_c.duty[ch];
      default: return bus_d.duty[ch];
    endcase
  endfunction

  function automatic logic [3:0] get_led(input int inst);
    case (inst)
      0:       return bus_a.led_out;
      1:       return bus_b.led_out;
      2:       return bus_c.led_out;
      default: return bus_d.led_out;
    endcase
  endfunction

  task automatic wait_duty(input string name, input int inst, input int ch,
                           input logic [7:0] val, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (get_duty(inst, ch) != val && n < budget);
    check({name, "_reached"}, 32'(get_duty(inst, ch)), 32'(val));
  endtask

  task automatic count_high(input int inst, input int ch, output int cnt);
    logic [3:0] l;
    cnt = 0;
    repeat (256) begin
      @(negedge clk);
      l = get_led(inst);
      if (l[ch]) cnt++;
    end
  endtask

  task automatic seq_a();
    int n, cnt, total;
    rst_a = 1'b1;
    bus_a.led_in  = 4'b1111;
    bus_a.fade_en = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("a_reset_led_out", 32'(bus_a.led_out), 32'h0);
      check("a_reset_busy", 32'(bus_a.busy), 32'h0);
    end
    #2 rst_a = 1'b0;
    repeat (2) @(negedge clk);
    check("a_busy_after_release", 32'(bus_a.busy), 32'h1);
    #2 rst_a = 1'b1;
    bus_a.led_in = 4'b0001;
    for (int k = 1; k <= 255; k++) exp_q_a.push_back(32'(k));
    @(negedge clk);
    check("a_rereset_busy", 32'(bus_a.busy), 32'h0);
    #2 rst_a = 1'b0;
    wait_duty("a_first_step", 0, 0, 8'd1, 1000, n);
    check("a_first_step_cycle", 32'(n), 32'd256);
    check("a_busy_rising", 32'(bus_a.busy), 32'h1);
    total = n;
    count_high(0, 0, cnt);
    check("a_high_count_d1", 32'(cnt), 32'd1);
    total += 256;
    wait_duty("a_mid", 0, 0, 8'd128, 70000, n);
    total += n;
    count_high(0, 0, cnt);
    check("a_high_count_d128", 32'(cnt), 32'd128);
    total += 256;
    wait_duty("a_full", 0, 0, 8'd255, 70000, n);
    total += n;
    check("a_full_rise_cycles", 32'(total), 32'd65280);
    check("a_busy_at_255_edge", 32'(bus_a.busy), 32'h1);
    @(negedge clk);
    check("a_busy_settled", 32'(bus_a.busy), 32'h0);
    count_high(0, 0, cnt);
    check("a_high_count_d255", 32'(cnt), 32'd256);
  endtask

  task automatic seq_b();
    int n;
    rst_b = 1'b1;
    bus_b.led_in  = 4'b0001;
    bus_b.fade_en = 1'b0;
    exp_q_b.push_back(32'h0000_00FF);
    @(negedge clk);
    #2 rst_b = 1'b0;
    wait_duty("b_bypass_settle", 1, 0, 8'hFF, 600, n);
    for (int k = 1; k <= 255; k++) exp_q_b.push_back({8'd0, 8'd0, 8'(k), 8'(255 - k)});
    bus_b.fade_en = 1'b1;
    bus_b.led_in  = 4'b0010;
    wait_duty("b_handoff", 1, 1, 8'hFF, 70000, n);
    check("b_handoff_cycles", 32'(n), 32'd65280);
    check("b_ch0_off", 32'(get_duty(1, 0)), 32'h0);
    repeat (2) @(negedge clk);
    check("b_busy_settled", 32'(bus_b.busy), 32'h0);
    check("b_led_out", 32'(bus_b.led_out), 32'h2);
  endtask

  task automatic seq_c();
    int n;
    rst_c = 1'b1;
    bus_c.led_in  = 4'b0001;
    bus_c.fade_en = 1'b1;
    for (int k = 1; k <= 100; k++) exp_q_c.push_back(32'(k));
    for (int k = 99; k >= 50; k--) exp_q_c.push_back(32'(k));
    exp_q_c.push_back(32'd51);
    @(negedge clk);
    #2 rst_c = 1'b0;
    wait_duty("c_rise_100", 2, 0, 8'd100, 30000, n);
    bus_c.led_in = 4'b0000;
    wait_duty("c_reverse_99", 2, 0, 8'd99, 1000, n);
    check("c_reverse_latency", 32'(n), 32'd256);
    wait_duty("c_fall_50", 2, 0, 8'd50, 20000, n);
    bus_c.led_in = 4'b0001;
    wait_duty("c_reverse_51", 2, 0, 8'd51, 1000, n);
    check("c_reverse_up_latency", 32'(n), 32'd256);
    // Bypass from a clean reset.
    #2 rst_c = 1'b1;
    bus_c.led_in  = 4'b1000;
    bus_c.fade_en = 1'b0;
    exp_q_c.push_back(32'hFF00_0000);
    @(negedge clk);
    check("c_reset_duty", bus_c.duty, 32'h0);
    #2 rst_c = 1'b0;
    @(negedge clk);
    check("c_bypass_busy", 32'(bus_c.busy), 32'h1);
    wait_duty("c_bypass", 2, 3, 8'hFF, 600, n);
    check("c_bypass_cycles", 32'(n + 1), 32'd256);
    check("c_bypass_led_lag", 32'(bus_c.led_out), 32'h0);
    @(negedge clk);
    check("c_bypass_led_on", 32'(bus_c.led_out), 32'h8);
    check("c_bypass_busy_clear", 32'(bus_c.busy), 32'h0);
  endtask

  task automatic seq_d();
    int n;
    rst_d = 1'b1;
    bus_d.led_in  = 4'b0100;
    bus_d.fade_en = 1'b1;
    @(negedge clk);
    #2 rst_d = 1'b0;
    wait_duty("d_first_step", 3, 2, 8'd1, 2000, n);
    check("d_first_step_cycles", 32'(n), 32'd1536);
    wait_duty("d_rise_16", 3, 2, 8'd16, 30000, n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus_d.led_out[2] !== 1'b1 && n < 2000);
    check("d_led_on_before_reset", 32'(bus_d.led_out[2]), 32'h1);
    #1 rst_d = 1'b1;
    #1;
    check("d_async_led_out", 32'(bus_d.led_out), 32'h0);
    check("d_async_busy", 32'(bus_d.busy), 32'h0);
    check("d_async_duty", bus_d.duty, 32'h0);
    check("d_async_div_cnt", 32'(u_d.div_cnt), 32'h0);
    check("d_async_pwm_cnt", 32'(u_d.pwm_cnt), 32'h0);
    check("d_async_fade_cnt", 32'(u_d.fade_cnt), 32'h0);
    #1 rst_d = 1'b0;
    wait_duty("d_restart", 3, 2, 8'd1, 2000, n);
    check("d_restart_cycles", 32'(n), 32'd1536);
  endtask

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      seq_a();
      seq_b();
      seq_c();
      seq_d();
    join
    repeat (4) @(negedge clk);
    check("sb_a_drain", 32'(exp_q_a.size()), 32'h0);
    check("sb_b_drain", 32'(exp_q_b.size()), 32'h0);
    check("sb_c_drain", 32'(exp_q_c.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
